// File: rtl/jstk_pkg.sv
// jstk_pkg: shared state type and constants for the Pmod JSTK2 SPI reader
package jstk_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CS_SETUP, S_SHIFT, S_GAP, S_DONE} state_t;
    localparam int SCK_HALF_DEF = 50;
    localparam int CS_SETUP_DEF = 1500;
    localparam int BYTE_GAP_DEF = 1000;
    localparam int POLL_CYC_DEF = 1_000_000;
    localparam int NUM_BYTES = 5;
    localparam logic [9:0] POS_CENTER = 10'd512;
endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: SPI mode-0 single-byte receive engine, MSB first
module spi_byte_rx import jstk_pkg::*; #(
    parameter int SCK_HALF = SCK_HALF_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       miso,
    output logic       sck,
    output logic       done,
    output logic [7:0] data
);
    logic        active;
    logic [31:0] cnt;
    logic [2:0]  nbit;
    logic [7:0]  sh;

    assign data = sh;

    // low half then high half per bit; sample on the last clk of each high half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            nbit   <= '0;
            sck    <= 1'b0;
            sh     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active <= 1'b1;
                cnt    <= '0;
                nbit   <= '0;
                sck    <= 1'b0;
            end else if (active) begin
                if (cnt == 32'(SCK_HALF - 1)) begin
                    cnt <= '0;
                    sck <= ~sck;
                    if (sck) begin
                        sh     <= {sh[6:0], miso};
                        nbit   <= nbit + 3'd1;
                        active <= nbit != 3'd7;
                        done   <= nbit == 3'd7;
                    end
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: rtl/jstk2_spi_reader.sv
// jstk2_spi_reader: periodic 5-byte SPI poll of a Pmod JSTK2, publishes position and buttons
module jstk2_spi_reader import jstk_pkg::*; #(
    parameter int SCK_HALF = SCK_HALF_DEF,
    parameter int CS_SETUP = CS_SETUP_DEF,
    parameter int BYTE_GAP = BYTE_GAP_DEF,
    parameter int POLL_CYC = POLL_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       jstk_miso,
    output logic       jstk_sck,
    output logic       jstk_mosi,
    output logic       jstk_cs,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       btn_jstk,
    output logic       btn_trig,
    output logic       sample_valid,
    output logic       busy
);
    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [2:0]  byte_idx, byte_idx_n;
    logic [1:0]  miso_sync;
    logic [7:0]  x_lo, y_lo;
    logic [1:0]  x_hi, y_hi;
    logic        start, rx_done, cap, last_byte, in_txn;
    logic [7:0]  rx_data;

    assign jstk_mosi = 1'b0;
    assign cap       = state == S_SHIFT && rx_done;
    assign last_byte = byte_idx == 3'(NUM_BYTES - 1);
    assign in_txn    = state_n inside {S_CS_SETUP, S_SHIFT, S_GAP};

    spi_byte_rx #(.SCK_HALF(SCK_HALF)) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .miso (miso_sync[1]),
        .sck  (jstk_sck),
        .done (rx_done),
        .data (rx_data)
    );

    // sequence poll wait, CS setup, five bytes with gaps, then output capture
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        byte_idx_n = byte_idx;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = enable ? cnt + 32'd1 : '0;
                if (enable && cnt == 32'(POLL_CYC - 1)) begin
                    state_n = S_CS_SETUP;
                    cnt_n   = '0;
                end
            end
            S_CS_SETUP: begin
                cnt_n = cnt + 32'd1;
                if (cnt == 32'(CS_SETUP - 1)) begin
                    state_n    = S_SHIFT;
                    cnt_n      = '0;
                    byte_idx_n = '0;
                    start      = 1'b1;
                end
            end
            S_SHIFT: if (rx_done) begin
                byte_idx_n = byte_idx + 3'd1;
                state_n    = last_byte ? S_DONE : S_GAP;
            end
            S_GAP: begin
                cnt_n = cnt + 32'd1;
                if (cnt == 32'(BYTE_GAP - 1)) begin
                    state_n = S_SHIFT;
                    cnt_n   = '0;
                    start   = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // state, synchronizer, receive staging and published outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            byte_idx     <= '0;
            miso_sync    <= '0;
            x_lo         <= '0;
            x_hi         <= '0;
            y_lo         <= '0;
            y_hi         <= '0;
            jstk_cs      <= 1'b1;
            busy         <= 1'b0;
            x_pos        <= POS_CENTER;
            y_pos        <= POS_CENTER;
            btn_jstk     <= 1'b0;
            btn_trig     <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            byte_idx     <= byte_idx_n;
            miso_sync    <= {miso_sync[0], jstk_miso};
            jstk_cs      <= !in_txn;
            busy         <= in_txn;
            sample_valid <= state_n == S_DONE;
            if (cap && byte_idx == 3'd0) x_lo <= rx_data;
            if (cap && byte_idx == 3'd1) x_hi <= rx_data[1:0];
            if (cap && byte_idx == 3'd2) y_lo <= rx_data;
            if (cap && byte_idx == 3'd3) y_hi <= rx_data[1:0];
            if (state_n == S_DONE) begin
                x_pos    <= {x_hi, x_lo};
                y_pos    <= {y_hi, y_lo};
                btn_jstk <= rx_data[0];
                btn_trig <= rx_data[1];
            end
        end
    end
endmodule

// File: tb/tb_jstk2_spi_reader.sv
// tb_jstk2_spi_reader: JSTK2 slave model, timing monitor and data checks for jstk2_spi_reader
module tb_jstk2_spi_reader;
    localparam int SCK_HALF = 2;
    localparam int CS_SETUP = 6;
    localparam int BYTE_GAP = 4;
    localparam int POLL_CYC = 20;

    typedef struct {
        logic [39:0] frame;
        int          ex;
        int          ey;
        bit          bj;
        bit          bt;
    } vec_t;

    logic       clk = 0, rst_n = 0, enable = 0, jstk_miso = 0;
    logic       jstk_sck, jstk_mosi, jstk_cs, btn_jstk, btn_trig, sample_valid, busy;
    logic [9:0] x_pos, y_pos;

    int n_checks = 0, n_fail = 0;
    logic [39:0] frame = '0, sreg = '0;
    bit load_pending = 1;

    int rises = 0, low_run = 0, hi_len = 0, cs_high_run = 0, last_hi_run = 0, last_rises = 0;
    int setup_run = 0, min_gap = 1000, gap_cnt = 0, sv_count = 0;
    int mosi_bad = 0, sck_cs_bad = 0, busy_bad = 0, hold_bad = 0, half_bad = 0, sv_bad = 0;
    logic prev_cs = 1, prev_sck = 0, prev_sv = 0, prev_bj = 0, prev_bt = 0;
    logic [9:0] prev_x = 0, prev_y = 0;

    jstk2_spi_reader #(.SCK_HALF(SCK_HALF), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP), .POLL_CYC(POLL_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .jstk_miso(jstk_miso),
        .jstk_sck(jstk_sck), .jstk_mosi(jstk_mosi), .jstk_cs(jstk_cs),
        .x_pos(x_pos), .y_pos(y_pos), .btn_jstk(btn_jstk), .btn_trig(btn_trig),
        .sample_valid(sample_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // JSTK2 slave: first bit on CS fall, next bit after each SCK fall
    always @(negedge jstk_cs or negedge jstk_sck or posedge jstk_cs) begin
        if (jstk_cs) load_pending = 1;
        else begin
            sreg = load_pending ? frame : {sreg[38:0], 1'b0};
            load_pending = 0;
            jstk_miso = sreg[39];
        end
    end

    // bus monitor sampled on the falling clk edge
    always @(negedge clk) begin
        if (!rst_n) cs_high_run = 0;
        else begin
            if (jstk_mosi) mosi_bad++;
            if (jstk_cs && jstk_sck) sck_cs_bad++;
            if (busy == jstk_cs) busy_bad++;
            if (!sample_valid && {x_pos, y_pos, btn_jstk, btn_trig} != {prev_x, prev_y, prev_bj, prev_bt}) hold_bad++;
            if (sample_valid) begin
                sv_count++;
                if (prev_sv || !jstk_cs || prev_cs) sv_bad++;
            end
            if (jstk_cs) begin
                if (!prev_cs) last_rises = rises;
                cs_high_run++;
            end else begin
                if (prev_cs) begin
                    last_hi_run = cs_high_run;
                    cs_high_run = 0; rises = 0; low_run = 0; hi_len = 0; min_gap = 1000; gap_cnt = 0;
                end
                if (jstk_sck) begin
                    if (!prev_sck) begin
                        rises++;
                        if (rises == 1) setup_run = low_run;
                        else if (rises % 8 == 1) begin
                            gap_cnt++;
                            if (low_run < min_gap) min_gap = low_run;
                        end else if (low_run != SCK_HALF) half_bad++;
                        low_run = 0;
                        hi_len = 0;
                    end
                    hi_len++;
                end else begin
                    if (prev_sck && hi_len != SCK_HALF) half_bad++;
                    low_run++;
                end
            end
        end
        prev_cs = jstk_cs; prev_sck = jstk_sck; prev_sv = sample_valid;
        prev_x = x_pos; prev_y = y_pos; prev_bj = btn_jstk; prev_bt = btn_trig;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_rng(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
        end
    endtask

    function automatic void model(input logic [39:0] f, output int ex, output int ey, output bit bj, output bit bt);
        int b[5];
        for (int k = 0; k < 5; k++) b[k] = int'(f[39 - 8 * k -: 8]);
        ex = b[0] + 256 * (b[1] % 4);
        ey = b[2] + 256 * (b[3] % 4);
        bj = bit'(b[4] % 2);
        bt = bit'((b[4] / 2) % 2);
    endfunction

    task automatic wait_cs_low(input string name);
        for (int i = 0; i < 300 && jstk_cs; i++) @(negedge clk);
        check({name, "_cs_fall"}, jstk_cs, 0);
    endtask

    task automatic count_to_cs_low(input string name);
        int n;
        for (n = 1; n < 200; n++) begin
            @(negedge clk);
            if (!jstk_cs) break;
        end
        check({name, "_poll_cycles"}, n, POLL_CYC);
    endtask

    task automatic finish_txn(input string name, input int ex, input int ey, input bit bj, input bit bt);
        int snap;
        snap = sv_count;
        for (int i = 0; i < 1000 && !sample_valid; i++) @(negedge clk);
        check({name, "_sv"}, sample_valid, 1);
        check({name, "_x"}, x_pos, ex);
        check({name, "_y"}, y_pos, ey);
        check({name, "_bj"}, btn_jstk, bj);
        check({name, "_bt"}, btn_trig, bt);
        repeat (2) @(negedge clk);
        check({name, "_sv_pulses"}, sv_count - snap, 1);
        check({name, "_rises"}, last_rises, 40);
        check({name, "_gaps"}, gap_cnt, 4);
        check_rng({name, "_setup"}, setup_run, CS_SETUP + SCK_HALF, 1000);
        check_rng({name, "_gap_len"}, min_gap, BYTE_GAP + SCK_HALF, 999);
    endtask

    task automatic run_txn(input string name, input logic [39:0] f, input int ex, input int ey, input bit bj, input bit bt);
        frame = f;
        wait_cs_low(name);
        @(negedge clk);
        check_rng({name, "_idle"}, last_hi_run, POLL_CYC, POLL_CYC + 1);
        finish_txn(name, ex, ey, bj, bt);
    endtask

    task automatic reset_checks(input string name);
        check({name, "_cs"}, jstk_cs, 1);
        check({name, "_sck"}, jstk_sck, 0);
        check({name, "_mosi"}, jstk_mosi, 0);
        check({name, "_x"}, x_pos, 512);
        check({name, "_y"}, y_pos, 512);
        check({name, "_btns"}, {btn_jstk, btn_trig}, 0);
        check({name, "_sv"}, sample_valid, 0);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        logic [63:0] r;
        logic [39:0] f;
        int ex, ey, snap;
        bit bj, bt;
        tbl[0] = '{40'h34_02_FF_03_03, 564, 1023, 1, 1};
        tbl[1] = '{40'h00_FC_FF_FE_FC, 0, 767, 0, 0};
        tbl[2] = '{40'hFF_FF_00_00_01, 1023, 0, 1, 0};
        tbl[3] = '{40'h00_01_00_02_02, 256, 512, 0, 1};
        tbl[4] = '{40'hA5_FD_5A_01_FE, 421, 346, 0, 1};
        enable = 1;
        #13;
        reset_checks("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 5; i++) run_txn($sformatf("tbl%0d", i), tbl[i].frame, tbl[i].ex, tbl[i].ey, tbl[i].bj, tbl[i].bt);
        for (int i = 0; i < 8; i++) begin
            r = {$urandom(), $urandom()};
            f = r[39:0];
            model(f, ex, ey, bj, bt);
            run_txn($sformatf("rnd%0d", i), f, ex, ey, bj, bt);
        end

        frame = 40'h12_03_34_01_02;
        wait_cs_low("en_drop");
        for (int i = 0; i < 400 && rises < 12; i++) @(negedge clk);
        enable = 0;
        finish_txn("en_drop", 786, 308, 0, 1);
        snap = 0;
        repeat (60) begin
            @(negedge clk);
            if (!jstk_cs) snap++;
        end
        check("en_cs_held_high", snap, 0);
        frame = 40'h80_00_80_01_00;
        enable = 1;
        count_to_cs_low("en_resume");
        finish_txn("en_resume", 128, 384, 0, 0);

        frame = 40'hC3_02_3C_01_01;
        wait_cs_low("rst_mid");
        for (int i = 0; i < 400 && rises < 20; i++) @(negedge clk);
        #2 rst_n = 0;
        #1 reset_checks("rst_mid");
        snap = sv_count;
        repeat (3) @(negedge clk);
        frame = 40'h5A_01_A5_02_03;
        rst_n = 1;
        count_to_cs_low("post_rst");
        check("rst_no_sv", sv_count - snap, 0);
        finish_txn("post_rst", 346, 677, 1, 1);

        check("mosi_zero", mosi_bad, 0);
        check("sck_low_when_cs_high", sck_cs_bad, 0);
        check("busy_vs_cs", busy_bad, 0);
        check("outputs_hold", hold_bad, 0);
        check("sck_half_periods", half_bad, 0);
        check("sv_at_cs_rise", sv_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jstk2_spi_reader.md
JSTK2_SPI_READER -- requirements
Module: jstk2_spi_reader

Interface
REQ-001 SHALL have parameter SCK_HALF, default 50: clk cycles per SCK half-period (1 MHz SCK at 100 MHz).
REQ-002 SHALL have parameter CS_SETUP, default 1500: clk cycles from CS fall to first SCK rise (15 us).
REQ-003 SHALL have parameter BYTE_GAP, default 1000: clk cycles of SCK-low idle between bytes (10 us).
REQ-004 SHALL have parameter POLL_CYC, default 1_000_000: idle clk cycles between transactions (10 ms).
REQ-005 clk  in  1  100 MHz system clock; the only clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  high permits new transactions.
REQ-008 jstk_miso  in  1  SPI data from Pmod JSTK2.
REQ-009 jstk_sck  out  1  SPI clock, mode 0.
REQ-010 jstk_mosi  out  1  SPI data to Pmod JSTK2.
REQ-011 jstk_cs  out  1  chip select, active-low.
REQ-012 x_pos  out  10  latest X reading, 0..1023.
REQ-013 y_pos  out  10  latest Y reading, 0..1023.
REQ-014 btn_jstk  out  1  joystick push-button, 1 = pressed.
REQ-015 btn_trig  out  1  trigger button, 1 = pressed.
REQ-016 sample_valid  out  1  one-cycle pulse on output update.
REQ-017 busy  out  1  high while jstk_cs is low.

Function
REQ-018 States: IDLE, CS_SETUP, SHIFT, GAP, DONE; all registered.
REQ-019 IDLE: poll counter increments only while enable=1, clears while enable=0; at POLL_CYC-1 next state CS_SETUP, jstk_cs falls.
REQ-020 CS_SETUP: hold SCK=0 for CS_SETUP cycles, then SHIFT.
REQ-021 SHIFT: 8 bits MSB first; each bit = SCK_HALF cycles low then SCK_HALF cycles high.
REQ-022 jstk_mosi SHALL be constant 0 (no command sent).
REQ-023 jstk_miso SHALL pass a 2-flop synchronizer; bit sampled on last clk of each SCK-high phase.
REQ-024 After bytes 0-3: GAP for BYTE_GAP cycles with SCK=0, then SHIFT; after byte 4: DONE.
REQ-025 DONE: jstk_cs rises; all five outputs updated in the same cycle; sample_valid high that one cycle; next state IDLE, poll counter 0.
REQ-026 Byte map: b0 = X[7:0], b1[1:0] = X[9:8], b2 = Y[7:0], b3[1:0] = Y[9:8], b4[0] = btn_jstk, b4[1] = btn_trig; b1[7:2], b3[7:2], b4[7:2] ignored.
REQ-027 Outputs SHALL hold previous values between DONE events; partial receive data never visible.
REQ-028 enable falling mid-transaction SHALL NOT abort; transaction completes, then IDLE waits for enable.
REQ-029 Exactly 40 SCK rising edges per transaction; SCK SHALL be 0 whenever jstk_cs=1.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, jstk_cs=1, jstk_sck=0, jstk_mosi=0, x_pos=512, y_pos=512, buttons=0, sample_valid=0, busy=0, all counters 0.
REQ-031 Reset mid-transaction SHALL discard partial data; after release, first transaction starts after POLL_CYC enabled cycles.

Structure
REQ-032 Shared package jstk_pkg SHALL hold the state enum, default timing constants, byte count (5) and reset centre value (512).
REQ-033 One sub-module spi_byte_rx SHALL implement the mode-0 single-byte shift engine (start/done handshake, 8-bit result); the top-level FSM sequences bytes, gaps and output capture.

Verification
REQ-034 Bench parameters SCK_HALF=2, CS_SETUP=6, BYTE_GAP=4, POLL_CYC=20, behavioural JSTK2 slave driving MISO on SCK falling edges.
REQ-035 Slave bytes 34,02,FF,03,03 -> x_pos=564, y_pos=1023, btn_jstk=1, btn_trig=1, single sample_valid pulse at CS rise.
REQ-036 Slave bytes 00,FC,FF,FE,FC -> x_pos=0, y_pos=767, btn_jstk=0, btn_trig=0 (upper bits ignored).
REQ-037 Timing check -> 40 SCK rises per CS-low window, >=6 cycles CS fall to first rise, 4-cycle SCK-low gaps, MOSI always 0, 20 idle cycles between CS rise and next fall.
REQ-038 enable dropped during byte 1 -> transaction completes, sample_valid pulses once, CS stays high until enable returns plus 20 cycles.
REQ-039 rst_n low during byte 2 -> jstk_cs=1 and SCK=0 without clock edge, x_pos=y_pos=512, no sample_valid; after release, next transaction delivers correct data.
